// File: rtl/point_stream_framer.sv
// point_stream_framer: hunts a sync preamble in a UART byte stream, assembles points MSB-first and buffers them in a FIFO
// Optional feature macro: POINT_FRAMER_CHECKSUM_EN (XOR checksum byte after END_WORD, adds frame_err).
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   rx_valid, rx_data       byte strobe and byte from the UART receiver
//   flush                   return to HUNT and empty the FIFO (overflow is kept)
//   out_valid, out_ready    output handshake; out_point is the FIFO head
//   fifo_level              FIFO occupancy
//   drawing                 high while a frame is being received
//   frame_done, frame_abort one-cycle end-of-frame / point-limit pulses
//   overflow                sticky: a point was dropped on a full FIFO, cleared at frame start
//   frame_err               checksum mismatch of the last frame (checksum build only)
module point_stream_framer #(
    parameter int          BYTES_PER_POINT = 4,
    parameter int          SYNC_LEN        = 8,
    parameter logic [7:0]  SYNC_BYTE       = 8'h00,
    parameter logic [31:0] END_WORD        = 32'h01010101,
    parameter int          MAX_PTS         = 20000,
    parameter int          FIFO_DEPTH      = 16,
    localparam int         POINT_W         = 8 * BYTES_PER_POINT,
    localparam int         LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [POINT_W-1:0] out_point,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               drawing,
    output logic               frame_done,
    output logic               frame_abort,
`ifdef POINT_FRAMER_CHECKSUM_EN
    output logic               frame_err,
`endif
    output logic               overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BC_W = BYTES_PER_POINT > 1 ? $clog2(BYTES_PER_POINT) : 1;
    localparam int PC_W = $clog2(MAX_PTS + 1);
    localparam logic [POINT_W-1:0] END_PT    = POINT_W'(END_WORD);
    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES_PER_POINT - 1);
    localparam logic [7:0]         SYNC_LAST = 8'(SYNC_LEN - 1);
    localparam logic [PC_W-1:0]    PT_MAX    = PC_W'(MAX_PTS);
    localparam logic [LVL_W-1:0]   FULL      = LVL_W'(FIFO_DEPTH);

    typedef enum logic {HUNT, DRAW} state_t;
    state_t state, state_nx;

    logic [7:0]         sync_cnt;
    logic [BC_W-1:0]    byte_cnt;
    logic [PC_W-1:0]    pt_cnt;
    logic [POINT_W-1:0] word, word_nx;
    logic [POINT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic push_pend, push_ok, pop;
    logic sync_hit, frame_start, pt_last, is_end, is_abort, pt_push, done_now;
    logic chk_wait;

    assign drawing   = state == DRAW;
    assign out_valid = fifo_level != '0;
    assign out_point = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    // a pop in the same cycle frees the slot the pending push needs
    assign push_ok   = push_pend && (fifo_level != FULL || pop);

    always_comb begin
        word_nx     = POINT_W'({word, rx_data});
        sync_hit    = state == HUNT && rx_valid && rx_data == SYNC_BYTE;
        frame_start = sync_hit && sync_cnt == SYNC_LAST;
        pt_last     = state == DRAW && rx_valid && !chk_wait && byte_cnt == LAST_BYTE;
        is_end      = pt_last && word_nx == END_PT;
        is_abort    = pt_last && !is_end && pt_cnt == PT_MAX;
        pt_push     = pt_last && !is_end && !is_abort;
`ifdef POINT_FRAMER_CHECKSUM_EN
        done_now    = state == DRAW && rx_valid && chk_wait;
`else
        done_now    = is_end;
`endif
        state_nx = state;
        if (flush)
            state_nx = HUNT;
        else if (frame_start)
            state_nx = DRAW;
        else if (done_now || is_abort)
            state_nx = HUNT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= HUNT;
        else
            state <= state_nx;
    end

    // the completed point stays in word for one cycle and is pushed from there;
    // a byte arriving in that cycle only updates word after the push has sampled it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_cnt    <= '0;
            byte_cnt    <= '0;
            pt_cnt      <= '0;
            word        <= '0;
            push_pend   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else if (flush) begin
            sync_cnt    <= '0;
            byte_cnt    <= '0;
            push_pend   <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            push_pend   <= pt_push;
            frame_done  <= done_now;
            frame_abort <= is_abort;
            if (state == HUNT && rx_valid)
                sync_cnt <= sync_hit && !frame_start ? sync_cnt + 8'd1 : '0;
            if (frame_start) begin
                byte_cnt <= '0;
                pt_cnt   <= '0;
            end else if (state == DRAW && rx_valid) begin
                word     <= word_nx;
                byte_cnt <= byte_cnt == LAST_BYTE ? '0 : byte_cnt + 1'b1;
                if (pt_push)
                    pt_cnt <= pt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (frame_start)
                overflow <= 1'b0;
            else if (push_pend && !push_ok)
                overflow <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok != pop)
                fifo_level <= push_ok ? fifo_level + 1'b1 : fifo_level - 1'b1;
        end
    end

`ifdef POINT_FRAMER_CHECKSUM_EN
    logic [7:0] csum, pt_xor;

    // pt_xor folds the bytes of the point in progress; csum only takes whole non-END points
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_wait  <= 1'b0;
            csum      <= '0;
            pt_xor    <= '0;
            frame_err <= 1'b0;
        end else if (flush) begin
            chk_wait  <= 1'b0;
            pt_xor    <= '0;
        end else if (frame_start) begin
            chk_wait  <= 1'b0;
            csum      <= '0;
            pt_xor    <= '0;
            frame_err <= 1'b0;
        end else if (state == DRAW && rx_valid) begin
            if (chk_wait) begin
                chk_wait  <= 1'b0;
                frame_err <= rx_data != csum;
            end else begin
                pt_xor <= pt_last ? 8'h00 : pt_xor ^ rx_data;
                if (is_end)
                    chk_wait <= 1'b1;
                else if (pt_last)
                    csum <= csum ^ pt_xor ^ rx_data;
            end
        end
    end
`else
    assign chk_wait = 1'b0;
`endif
endmodule

// File: tb/tb_point_stream_framer.sv
// tb_point_stream_framer: directed and randomized checks of point_stream_framer against a byte-stream frame parser model
module tb_point_stream_framer;
    localparam int FD = 4;
    localparam int MAXP = 5;
    localparam int SYNC_N = 8;
    localparam logic [31:0] END_PT = 32'h01010101;

    logic clk = 1'b0, reset_n = 1'b0, rx_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic out_valid, drawing, frame_done, frame_abort, overflow;
    logic [31:0] out_point;
    logic [2:0] fifo_level;
`ifdef POINT_FRAMER_CHECKSUM_EN
    logic frame_err;
    logic exp_err;
    logic [7:0] ck_bad = 8'h00;
`endif

    always #5 clk = ~clk;

    point_stream_framer #(.FIFO_DEPTH(FD), .MAX_PTS(MAXP)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_point(out_point),
        .fifo_level(fifo_level),
        .drawing(drawing),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
`ifdef POINT_FRAMER_CHECKSUM_EN
        .frame_err(frame_err),
`endif
        .overflow(overflow)
    );

    int n_cmp = 0, n_bad = 0;
    int ready_mode = 0;
    int gap_max = 0;
    int done_seen = 0, abort_seen = 0;
    int pb = 0, db = 0, ab = 0;
    int exp_done, exp_abort;
    logic [31:0] popped[$];
    logic [31:0] exp_pts[$];
    logic [7:0] sent[$];
    logic [7:0] fx = 8'h00;
    logic [31:0] pts[6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // consumer: out_ready chosen at the negedge; a pop happens at the next posedge
    initial forever begin
        @(negedge clk);
        out_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        if (out_valid && out_ready && reset_n)
            popped.push_back(out_point);
    end

    initial forever begin
        @(negedge clk);
        if (frame_done) done_seen++;
        if (frame_abort) abort_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        sent.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic send_sync();
        repeat (SYNC_N) send_byte(8'h00);
        fx = 8'h00;
    endtask

    task automatic send_point(input logic [31:0] p);
        for (int k = 3; k >= 0; k--) begin
            send_byte(p[8*k+:8]);
            fx = fx ^ p[8*k+:8];
        end
    endtask

    task automatic send_end();
        logic [31:0] e;
        e = END_PT;
        for (int k = 3; k >= 0; k--) send_byte(e[8*k+:8]);
`ifdef POINT_FRAMER_CHECKSUM_EN
        send_byte(fx ^ ck_bad);
`endif
    endtask

    function automatic logic [31:0] rnd_point();
        logic [31:0] p;
        do begin
            for (int k = 0; k < 4; k++) p[8*k+:8] = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
        end while (p == END_PT);
        return p;
    endfunction

    task automatic mark();
        pb = popped.size();
        db = done_seen;
        ab = abort_seen;
        sent.delete();
    endtask

    // reference: parse the byte stream sent since mark() into frames and points
    task automatic model();
        int run, n, i;
        bit in_f;
        logic [31:0] w;
        logic [7:0] x;
        run = 0; n = 0; i = 0; in_f = 0; x = 8'h00;
        exp_pts.delete();
        exp_done = 0;
        exp_abort = 0;
`ifdef POINT_FRAMER_CHECKSUM_EN
        exp_err = 1'b0;
`endif
        while (i < sent.size()) begin
            if (!in_f) begin
                run = sent[i] == 8'h00 ? run + 1 : 0;
                i++;
                if (run == SYNC_N) begin
                    in_f = 1; run = 0; n = 0; x = 8'h00;
`ifdef POINT_FRAMER_CHECKSUM_EN
                    exp_err = 1'b0;
`endif
                end
            end else if (i + 4 > sent.size()) begin
                break;
            end else begin
                w = {sent[i], sent[i+1], sent[i+2], sent[i+3]};
                i += 4;
                if (w == END_PT) begin
                    in_f = 0;
`ifdef POINT_FRAMER_CHECKSUM_EN
                    if (i < sent.size()) begin
                        exp_err = sent[i] != x;
                        exp_done++;
                        i++;
                    end
`else
                    exp_done++;
`endif
                end else if (n == MAXP) begin
                    in_f = 0;
                    exp_abort++;
                end else begin
                    exp_pts.push_back(w);
                    n++;
                    x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                end
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        model();
        check({tag, "_npts"}, popped.size() - pb, exp_pts.size());
        foreach (exp_pts[i])
            if (pb + i < popped.size()) check({tag, "_pt"}, popped[pb+i], exp_pts[i]);
        check({tag, "_done"}, done_seen - db, exp_done);
        check({tag, "_abort"}, abort_seen - ab, exp_abort);
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 1;
        idle(3);
        while (out_valid && n < 100) begin
            idle(1);
            n++;
        end
        check("drain", out_valid, 1'b0);
    endtask

    task automatic garbage();
        int g, run;
        logic [7:0] b;
        g = $urandom_range(1, 12);
        run = 0;
        for (int k = 0; k < g; k++) begin
            b = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
            if ((run == SYNC_N - 1 || k == g - 1) && b == 8'h00) b = 8'hA5;
            run = b == 8'h00 ? run + 1 : 0;
            send_byte(b);
        end
    endtask

    initial begin
        idle(3);
        check("rst_valid", out_valid, 1'b0);
        check("rst_point", out_point, 32'h0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_drawing", drawing, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_abort", frame_abort, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset_n = 1'b1;
        idle(2);

        // two points then END_WORD
        ready_mode = 1;
        mark();
        send_sync();
        send_point(32'h12345678);
        send_point(32'h00000ABC);
        send_end();
        idle(6);
        compare_stream("t1");
        check("t1_drawing", drawing, 1'b0);

        // broken preamble must not start a frame
        mark();
        repeat (7) send_byte(8'h00);
        send_byte(8'h05);
        check("t2_hunt", drawing, 1'b0);
        send_sync();
        check("t2_draw", drawing, 1'b1);
        send_point(32'hCAFE0042);
        send_end();
        idle(6);
        compare_stream("t2");

        // consumer stalled: latency, fill, overflow, stable head, then flush
        ready_mode = 0;
        idle(2);
        mark();
        send_sync();
        for (int k = 0; k < 5; k++) pts[k] = rnd_point();
        send_point(pts[0]);
        check("t3_lat1", out_valid, 1'b0);
        idle(1);
        check("t3_lat2", out_valid, 1'b1);
        for (int k = 1; k < 5; k++) send_point(pts[k]);
        idle(3);
        check("t3_level", fifo_level, 3'd4);
        check("t3_overflow", overflow, 1'b1);
        check("t3_head", out_point, pts[0]);
        idle(2);
        check("t3_hold", out_point, pts[0]);
        drain();
        check("t3_npts", popped.size() - pb, 4);
        for (int k = 0; k < 4; k++)
            if (pb + k < popped.size()) check("t3_pt", popped[pb+k], pts[k]);
        send_byte(8'h77);
        send_byte(8'h88);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("fl_level", fifo_level, 3'd0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_drawing", drawing, 1'b0);
        check("fl_overflow", overflow, 1'b1);

        // point limit: MAXP accepted, next one aborts
        ready_mode = 1;
        mark();
        send_sync();
        for (int k = 0; k < MAXP + 1; k++) send_point(rnd_point());
        idle(6);
        compare_stream("t4");
        check("t4_drawing", drawing, 1'b0);
        check("t4_overflow", overflow, 1'b0);

        // asynchronous reset mid-point with buffered points
        ready_mode = 0;
        idle(2);
        mark();
        send_sync();
        for (int k = 0; k < 3; k++) send_point(rnd_point());
        send_byte(8'h3C);
        send_byte(8'hC3);
        idle(2);
        check("t5_level", fifo_level, 3'd3);
        #2 reset_n = 1'b0;
        #1;
        check("t5_valid", out_valid, 1'b0);
        check("t5_point", out_point, 32'h0);
        check("t5_level0", fifo_level, 3'd0);
        check("t5_drawing", drawing, 1'b0);
        check("t5_done", frame_done, 1'b0);
        check("t5_abort", frame_abort, 1'b0);
        check("t5_overflow", overflow, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        ready_mode = 1;
        idle(2);
        mark();
        send_sync();
        send_point(rnd_point());
        send_point(rnd_point());
        send_end();
        idle(6);
        compare_stream("t5");

`ifdef POINT_FRAMER_CHECKSUM_EN
        mark();
        send_sync();
        send_point(32'h11223344);
        ck_bad = 8'h00;
        send_end();
        idle(4);
        check("ck_ok", frame_err, 1'b0);
        send_sync();
        send_point(32'h11223344);
        ck_bad = 8'h01;
        send_end();
        idle(4);
        check("ck_bad", frame_err, 1'b1);
        compare_stream("ck");
`endif

        // randomized frames with HUNT noise, byte gaps and random backpressure
        mark();
        gap_max = 2;
        for (int f = 0; f < 20; f++) begin
            int np;
            ready_mode = 2;
            garbage();
            send_sync();
            np = $urandom_range(0, 4);
            for (int k = 0; k < np; k++) send_point(rnd_point());
`ifdef POINT_FRAMER_CHECKSUM_EN
            ck_bad = $urandom_range(0, 1) ? 8'h00 : 8'h3C;
`endif
            send_end();
            drain();
        end
        gap_max = 0;
        compare_stream("rnd");
        check("rnd_overflow", overflow, 1'b0);
        check("rnd_drawing", drawing, 1'b0);
`ifdef POINT_FRAMER_CHECKSUM_EN
        check("rnd_err", frame_err, exp_err);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
